// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational fetch/decode/execute/memory,
// PC and register-file writeback on the rising clock edge.
module rv32i_core (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] rom_addr,
  input  logic [31:0] rom_in,
  output logic [31:0] ram_addr,
  output logic        ram_r,
  output logic [3:0]  ram_w,
  output logic [31:0] ram_out,
  input  logic [31:0] ram_in,
  output logic        brk
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  logic [XLEN-1:0] pc, next_pc;
  logic [XLEN-1:0] rf [NREG];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_v, rs2_v, alu_b, alu_y, wb_val;
  logic [XLEN-1:0] ld_addr, st_addr;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [3:0]      st_mask;
  logic            taken, wb_en, ld, is_brk;

  assign rom_addr = pc[31:2];

  assign opcode = rom_in[6:0];
  assign rd     = rom_in[11:7];
  assign f3     = rom_in[14:12];
  assign rs1    = rom_in[19:15];
  assign rs2    = rom_in[24:20];

  assign imm_i = {{20{rom_in[31]}}, rom_in[31:20]};
  assign imm_s = {{20{rom_in[31]}}, rom_in[31:25], rom_in[11:7]};
  assign imm_b = {{19{rom_in[31]}}, rom_in[31], rom_in[7], rom_in[30:25], rom_in[11:8], 1'b0};
  assign imm_u = {rom_in[31:12], 12'b0};
  assign imm_j = {{11{rom_in[31]}}, rom_in[31], rom_in[19:12], rom_in[20], rom_in[30:21], 1'b0};

  // x0 is hardwired to zero on the read side; it is never written
  assign rs1_v = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : rf[rs2];

  assign ld_addr = rs1_v + imm_i;
  assign st_addr = rs1_v + imm_s;
  assign ld_half = ld_addr[1] ? ram_in[31:16] : ram_in[15:0];

  always_comb begin
    ld_byte = ram_in[7:0];
    case (ld_addr[1:0])
      2'd1:    ld_byte = ram_in[15:8];
      2'd2:    ld_byte = ram_in[23:16];
      2'd3:    ld_byte = ram_in[31:24];
      default: ld_byte = ram_in[7:0];
    endcase
  end

  // Shared ALU for OP and OP-IMM; bit 30 selects SUB (register form only) and SRA
  assign alu_b = (opcode == OP_OP) ? rs2_v : imm_i;

  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000:  alu_y = ((opcode == OP_OP) && rom_in[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu_y = rs1_v << alu_b[4:0];
      3'b010:  alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_v < alu_b};
      3'b100:  alu_y = rs1_v ^ alu_b;
      3'b101:  alu_y = rom_in[30] ? XLEN'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'b110:  alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = rs1_v == rs2_v;
      3'b001:  taken = rs1_v != rs2_v;
      3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110:  taken = rs1_v < rs2_v;
      3'b111:  taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end

  // Instruction execute: next PC, writeback value and memory request
  always_comb begin
    next_pc  = pc + 32'd4;
    wb_en    = 1'b0;
    wb_val   = '0;
    ram_addr = '0;
    ram_out  = '0;
    ld       = 1'b0;
    st_mask  = 4'b0000;
    is_brk   = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        wb_en   = 1'b1;
        wb_val  = pc + 32'd4;
        next_pc = (rs1_v + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_LOAD: begin
        case (f3)
          3'b000:  begin ld = 1'b1; wb_val = {{24{ld_byte[7]}}, ld_byte}; end
          3'b001:  begin ld = 1'b1; wb_val = {{16{ld_half[15]}}, ld_half}; end
          3'b010:  begin ld = 1'b1; wb_val = ram_in; end
          3'b100:  begin ld = 1'b1; wb_val = {24'b0, ld_byte}; end
          3'b101:  begin ld = 1'b1; wb_val = {16'b0, ld_half}; end
          default: ld = 1'b0;
        endcase
        wb_en    = ld;
        ram_addr = ld ? ld_addr : '0;
      end
      OP_STORE: begin
        case (f3)
          3'b000:  begin st_mask = 4'b0001 << st_addr[1:0]; ram_out = {4{rs2_v[7:0]}}; end
          3'b001:  begin st_mask = st_addr[1] ? 4'b1100 : 4'b0011; ram_out = {2{rs2_v[15:0]}}; end
          3'b010:  begin st_mask = 4'b1111; ram_out = rs2_v; end
          default: st_mask = 4'b0000;
        endcase
        ram_addr = (st_mask != 4'b0000) ? st_addr : '0;
      end
      OP_IMM, OP_OP: begin wb_en = 1'b1; wb_val = alu_y; end
      OP_SYSTEM: begin
        if (rom_in == INSN_EBREAK) begin
          is_brk  = 1'b1;
          next_pc = pc;
        end
      end
      default: wb_en = 1'b0;
    endcase
  end

  // Reset suppresses any side effect of the instruction in flight
  assign ram_r = ld & ~rst;
  assign ram_w = rst ? 4'b0000 : st_mask;
  assign brk   = is_brk & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en && (rd != 5'd0)) rf[rd] <= wb_val;
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed-program bench for rv32i_core with an instruction-level reference
// model that predicts fetch address and memory-port activity every cycle.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] rom_addr;
  logic [31:0] rom_in;
  logic [31:0] ram_addr;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_out;
  logic [31:0] ram_in;
  logic        brk;

  rv32i_core dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_in(rom_in),
    .ram_addr(ram_addr), .ram_r(ram_r), .ram_w(ram_w), .ram_out(ram_out),
    .ram_in(ram_in), .brk(brk)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  int n_vec = 0;
  int n_err = 0;

  // Environment: ROM and RAM
  logic [31:0] rom [64];
  logic [31:0] mem [64];
  logic        clr_mem = 1'b1;
  logic        got_first = 1'b0;
  logic [3:0]  first_w = '0;
  logic [31:0] first_out = '0;
  logic [31:0] first_addr = '0;
  int          wptr = 0;

  assign rom_in = rom[rom_addr[5:0]];
  assign ram_in = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      got_first <= 1'b0;
    end else if (ram_w != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (ram_w[i]) mem[ram_addr[7:2]][8*i +: 8] <= ram_out[8*i +: 8];
      if (!got_first) begin
        first_w    <= ram_w;
        first_out  <= ram_out;
        first_addr <= ram_addr;
        got_first  <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] it(int op, int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] rt(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] st(int f3, int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] bt(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ut(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] jt(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return it(7'h13, 0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] sw(int rs2, int off);
    return st(2, rs2, 0, off);
  endfunction

  task automatic emit(input logic [31:0] ins);
    rom[wptr] = ins;
    wptr++;
  endtask

  // Reference model: architectural state and per-cycle predictions
  logic [31:0] m_pc = '0;
  logic [31:0] m_x [32];
  logic [31:0] m_mem [64];
  logic        e_r, e_brk;
  logic [3:0]  e_w;
  logic [31:0] e_addr, e_out;
  logic [31:0] nx_pc, nx_val;
  logic        nx_wr;
  logic [4:0]  nx_rd;

  function automatic logic [31:0] alu_m(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_eval();
    logic [31:0] ins, a, b, ii, is_, ib, iu, ij, ad, w;
    logic [2:0]  f3;
    logic [7:0]  by;
    logic [15:0] hw;
    logic        t;
    ins = rom[m_pc[7:2]];
    f3  = ins[14:12];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = 32'($signed(ins[31:20]));
    is_ = 32'($signed({ins[31:25], ins[11:7]}));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu  = {ins[31:12], 12'h000};
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e_r = 1'b0; e_w = '0; e_addr = '0; e_out = '0; e_brk = 1'b0;
    nx_pc = m_pc + 32'd4; nx_wr = 1'b0; nx_val = '0; nx_rd = ins[11:7];
    case (ins[6:0])
      7'h37: begin nx_wr = 1'b1; nx_val = iu; end
      7'h17: begin nx_wr = 1'b1; nx_val = m_pc + iu; end
      7'h6F: begin nx_wr = 1'b1; nx_val = m_pc + 32'd4; nx_pc = m_pc + ij; end
      7'h67: begin nx_wr = 1'b1; nx_val = m_pc + 32'd4; nx_pc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: t = a == b;
          3'd1: t = a != b;
          3'd4: t = $signed(a) < $signed(b);
          3'd5: t = $signed(a) >= $signed(b);
          3'd6: t = a < b;
          3'd7: t = a >= b;
          default: t = 1'b0;
        endcase
        if (t) nx_pc = m_pc + ib;
      end
      7'h03: begin
        ad = a + ii;
        w  = m_mem[ad[7:2]];
        by = 8'(w >> (8 * ad[1:0]));
        hw = 16'(w >> (16 * ad[1]));
        nx_wr = 1'b1;
        case (f3)
          3'd0: nx_val = 32'($signed(by));
          3'd1: nx_val = 32'($signed(hw));
          3'd2: nx_val = w;
          3'd4: nx_val = {24'h0, by};
          3'd5: nx_val = {16'h0, hw};
          default: nx_wr = 1'b0;
        endcase
        if (nx_wr) begin e_r = 1'b1; e_addr = ad; end
      end
      7'h23: begin
        ad = a + is_;
        case (f3)
          3'd0: begin e_w = 4'(1 << ad[1:0]); e_out = {4{b[7:0]}}; end
          3'd1: begin e_w = ad[1] ? 4'hC : 4'h3; e_out = {2{b[15:0]}}; end
          3'd2: begin e_w = 4'hF; e_out = b; end
          default: e_w = '0;
        endcase
        if (e_w != 0) e_addr = ad;
      end
      7'h13: begin nx_wr = 1'b1; nx_val = alu_m(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h33: begin nx_wr = 1'b1; nx_val = alu_m(f3, ins[30], a, b); end
      7'h73: if (ins == EBREAK) begin e_brk = 1'b1; nx_pc = m_pc; end
      default: ;
    endcase
    if (rst) begin e_r = 1'b0; e_w = '0; e_brk = 1'b0; end
  endtask

  // Compare on the falling edge, advance the model on the rising edge
  initial begin
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    forever begin
      @(negedge clk);
      model_eval();
      check("rom_addr", 32'(rom_addr), 32'(m_pc[31:2]));
      check("ram_r", 32'(ram_r), 32'(e_r));
      check("ram_w", 32'(ram_w), 32'(e_w));
      check("brk", 32'(brk), 32'(e_brk));
      if (e_r || e_w != 0) check("ram_addr", ram_addr, e_addr);
      if (e_w != 0) check("ram_out", ram_out, e_out);
      @(posedge clk);
      if (rst) begin
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
      end else begin
        m_pc = nx_pc;
        if (nx_wr && nx_rd != 0) m_x[nx_rd] = nx_val;
        for (int i = 0; i < 4; i++)
          if (e_w[i]) m_mem[e_addr[7:2]][8*i +: 8] = e_out[8*i +: 8];
      end
      if (clr_mem) for (int i = 0; i < 64; i++) m_mem[i] = '0;
    end
  end

  task automatic begin_prog();
    @(posedge clk); #1;
    rst = 1'b1;
    clr_mem = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = EBREAK;
    wptr = 0;
  endtask

  task automatic release_rst();
    @(posedge clk); #1 clr_mem = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_brk(input int max);
    int n = 0;
    while (!brk && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check("brk_reached", 32'(brk), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = EBREAK;

    // Reset state
    @(negedge clk); #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_brk", 32'(brk), 32'd0);
    check("rst_ram_w", 32'(ram_w), 32'd0);

    // P1: basic ADDI chain, EBREAK holds PC
    begin_prog();
    emit(addi(1, 0, 5));
    emit(addi(2, 1, -7));
    emit(EBREAK);
    release_rst();
    wait_brk(50);
    check("p1_brk_addr", 32'(rom_addr), 32'd2);
    check("p1_model_x1", m_x[1], 32'd5);
    check("p1_model_x2", m_x[2], 32'hFFFF_FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("p1_brk_hold", 32'(brk), 32'd1);
    check("p1_pc_hold", 32'(rom_addr), 32'd2);

    // P2: LUI/ADDI/SW then byte and halfword loads
    begin_prog();
    emit(ut(7'h37, 3, 'h12345));
    emit(addi(3, 3, 'h678));
    emit(sw(3, 4));
    emit(it(7'h03, 0, 4, 0, 5));
    emit(it(7'h03, 5, 5, 0, 6));
    emit(sw(4, 8));
    emit(sw(5, 12));
    emit(EBREAK);
    release_rst();
    wait_brk(50);
    check("p2_word", mem[1], 32'h1234_5678);
    check("p2_lb", mem[2], 32'h0000_0056);
    check("p2_lhu", mem[3], 32'h0000_1234);
    check("p2_first_w", 32'(first_w), 32'hF);
    check("p2_first_addr", first_addr, 32'd4);

    // P3: SB lane steering, sign/zero extension, misaligned halfword/word, NOP-like ops
    begin_prog();
    emit(addi(6, 0, 'hAB));
    emit(st(0, 6, 0, 3));
    emit(it(7'h03, 0, 7, 0, 3));
    emit(it(7'h03, 4, 8, 0, 3));
    emit(sw(7, 16));
    emit(sw(8, 20));
    emit(32'h0000_0073);
    emit(32'h0000_000F);
    emit(32'hFFFF_FFFF);
    emit(it(7'h03, 1, 9, 0, 3));
    emit(sw(9, 24));
    emit(st(1, 6, 0, 1));
    emit(it(7'h03, 2, 10, 0, 2));
    emit(sw(10, 28));
    emit(EBREAK);
    release_rst();
    wait_brk(60);
    check("p3_sb_w", 32'(first_w), 32'h8);
    check("p3_sb_out", first_out, 32'hABAB_ABAB);
    check("p3_sb_addr", first_addr, 32'd3);
    check("p3_lb", mem[4], 32'hFFFF_FFAB);
    check("p3_lbu", mem[5], 32'h0000_00AB);
    check("p3_lh_mis", mem[6], 32'hFFFF_AB00);
    check("p3_sh_word", mem[0], 32'hAB00_00AB);
    check("p3_lw_mis", mem[7], 32'hAB00_00AB);
    check("p3_brk_addr", 32'(rom_addr), 32'd14);

    // P4: branches, JAL, JALR with odd target
    begin_prog();
    emit(addi(7, 0, -1));
    emit(addi(8, 0, 1));
    emit(bt(4, 7, 8, 8));
    emit(addi(10, 0, 99));
    emit(bt(6, 7, 8, 8));
    emit(addi(11, 0, 7));
    emit(addi(9, 0, 'h40));
    emit(addi(0, 0, 0));
    emit(jt(1, 16));
    emit(addi(10, 0, 77));
    emit(addi(10, 0, 77));
    emit(addi(10, 0, 77));
    emit(sw(1, 0));
    emit(sw(10, 4));
    emit(sw(11, 8));
    emit(it(7'h67, 0, 0, 9, 3));
    emit(sw(9, 12));
    emit(EBREAK);
    release_rst();
    wait_brk(60);
    check("p4_jal_link", mem[0], 32'h24);
    check("p4_skipped", mem[1], 32'd0);
    check("p4_bltu_nt", mem[2], 32'd7);
    check("p4_jalr_tgt", mem[3], 32'h40);
    check("p4_brk_addr", 32'(rom_addr), 32'h11);

    // P5: ALU coverage
    begin_prog();
    emit(addi(1, 0, 1));
    emit(it(7'h13, 1, 1, 1, 31));
    emit(it(7'h13, 5, 2, 1, 'h404));
    emit(addi(3, 0, 36));
    emit(rt(0, 5, 4, 1, 3));
    emit(addi(5, 0, 3));
    emit(addi(6, 0, 5));
    emit(rt('h20, 0, 7, 5, 6));
    emit(addi(8, 0, -1));
    emit(addi(10, 0, 1));
    emit(rt(0, 3, 9, 10, 8));
    emit(addi(0, 0, 9));
    emit(sw(2, 0));
    emit(sw(4, 4));
    emit(sw(7, 8));
    emit(sw(9, 12));
    emit(sw(8, 16));
    emit(sw(0, 16));
    emit(rt(0, 2, 11, 8, 10));
    emit(it(7'h13, 4, 12, 8, 'h0F0));
    emit(it(7'h13, 3, 13, 10, -1));
    emit(it(7'h13, 2, 14, 8, 0));
    emit(ut(7'h17, 15, 1));
    emit(rt('h20, 5, 16, 1, 3));
    emit(rt(0, 1, 17, 10, 3));
    emit(rt(0, 6, 18, 5, 6));
    emit(rt(0, 7, 19, 5, 6));
    emit(it(7'h13, 7, 20, 8, 'h0F0));
    emit(it(7'h13, 6, 21, 5, -8));
    emit(rt(0, 4, 22, 5, 6));
    emit(it(7'h13, 5, 23, 1, 4));
    for (int r = 11; r <= 23; r++) emit(sw(r, 20 + 4 * (r - 11)));
    emit(EBREAK);
    release_rst();
    wait_brk(100);
    check("p5_srai", mem[0], 32'hF800_0000);
    check("p5_srl36", mem[1], 32'h0800_0000);
    check("p5_sub", mem[2], 32'hFFFF_FFFE);
    check("p5_sltu", mem[3], 32'd1);
    check("p5_x0", mem[4], 32'd0);
    check("p5_slt", mem[5], 32'd1);
    check("p5_auipc", mem[9], 32'h0000_1058);
    check("p5_sra", mem[10], 32'hF800_0000);

    // P6: reset asserted while a store is pending
    begin_prog();
    emit(addi(1, 0, 'h55));
    emit(sw(1, 0));
    emit(EBREAK);
    release_rst();
    begin
      int n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (rom_addr != 30'd1 && n < 20);
    end
    check("p6_at_store", 32'(rom_addr), 32'd1);
    rst = 1'b1;
    #1;
    check("p6_rst_gate_w", 32'(ram_w), 32'd0);
    @(posedge clk); #1;
    check("p6_no_store", mem[0], 32'd0);
    check("p6_pc_zero", 32'(rom_addr), 32'd0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
